// File: rtl/frequency_divider.sv
// frequency_divider: fractional-accumulator square-wave tone generator (no divider).
// Optional FREQDIV_RESYNC_EN: restart from a clean low phase whenever frequency changes.
module frequency_divider #(
    parameter int CLK_HZ = 50_000_000,
    parameter int FREQ_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FREQ_W-1:0] frequency,
    output logic              clk_out
);
    // acc stays below CLK_HZ, so acc + largest step must fit without wrapping.
    localparam int ACC_MAX = CLK_HZ + (32'd2 * ((32'd1 << FREQ_W) - 32'd1));
    localparam int ACC_W   = $clog2(ACC_MAX + 32'd1);
    localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLK_HZ);

    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] step_s;
    logic [ACC_W-1:0] sum_s;
    logic [ACC_W-1:0] acc_nxt_s;
    logic             clk_out_r;
    logic             clk_out_nxt_s;

`ifdef FREQDIV_RESYNC_EN
    logic [FREQ_W-1:0] prev_freq_r;
    logic              prev_valid_r;
    logic              resync_s;

    // prev_valid_r keeps the first edge after reset from being seen as a change.
    assign resync_s = prev_valid_r && (frequency != prev_freq_r);
`endif

    assign step_s  = ACC_W'({frequency, 1'b0});
    assign sum_s   = acc_r + step_s;
    assign clk_out = clk_out_r;

    // Next-state selection: silence, clamp to clk/2, wrap-and-toggle, or accumulate.
    always_comb begin
        acc_nxt_s     = acc_r;
        clk_out_nxt_s = clk_out_r;
`ifdef FREQDIV_RESYNC_EN
        if (resync_s) begin
            acc_nxt_s     = {ACC_W{1'b0}};
            clk_out_nxt_s = 1'b0;
        end else
`endif
        if (frequency == {FREQ_W{1'b0}}) begin
            acc_nxt_s     = {ACC_W{1'b0}};
            clk_out_nxt_s = 1'b0;
        end else if (step_s >= LIMIT) begin
            acc_nxt_s     = {ACC_W{1'b0}};
            clk_out_nxt_s = ~clk_out_r;
        end else if (sum_s >= LIMIT) begin
            acc_nxt_s     = sum_s - LIMIT;
            clk_out_nxt_s = ~clk_out_r;
        end else begin
            acc_nxt_s     = sum_s;
            clk_out_nxt_s = clk_out_r;
        end
    end

    // Accumulator and output phase registers; reset returns to silent low phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r     <= {ACC_W{1'b0}};
            clk_out_r <= 1'b0;
        end else begin
            acc_r     <= acc_nxt_s;
            clk_out_r <= clk_out_nxt_s;
        end
    end

`ifdef FREQDIV_RESYNC_EN
    // Remember the frequency seen on the previous edge for change detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_freq_r  <= {FREQ_W{1'b0}};
            prev_valid_r <= 1'b0;
        end else begin
            prev_freq_r  <= frequency;
            prev_valid_r <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_frequency_divider.sv
// Directed bench for frequency_divider at CLK_HZ=100: expected half-period lengths
// and output levels are queued when stimulus is applied, then popped as the DUT toggles.
module tb_frequency_divider;
    localparam int CLK_HZ = 100;
    localparam int FREQ_W = 11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [FREQ_W-1:0] frequency = '0;
    logic              clk_out;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_q[$];

    frequency_divider #(.CLK_HZ(CLK_HZ), .FREQ_W(FREQ_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .frequency(frequency),
        .clk_out  (clk_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs);
        int expv;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %0d, nothing expected", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            assert (obs === 32'(expv)) else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
            end
        end
    endtask

    // Counts rising edges until clk_out changes level (bounded).
    task automatic wait_toggle(output int n);
        logic start;
        start = clk_out;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (clk_out === start && n < 400);
    endtask

    initial begin
        int n;
        int hi;

        // 1: reset held with frequency=1, then period 100 from release
        rst_n = 1'b0;
        frequency = 11'd1;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (clk_out !== 1'b0) hi++;
        end
        exp_q.push_back(0);
        check("reset_hold_high_samples", 32'(hi));
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(50); exp_q.push_back(50); exp_q.push_back(50);
        for (int i = 0; i < 3; i++) begin
            wait_toggle(n);
            check("f1_half_period", 32'(n));
        end

        // 2: frequency=10 -> half period 5
        frequency = 11'd10;
        for (int i = 0; i < 4; i++) exp_q.push_back(5);
        for (int i = 0; i < 4; i++) begin
            wait_toggle(n);
            check("f10_half_period", 32'(n));
        end

        // 3: frequency=3 -> 17,17,16 repeating
        frequency = 11'd3;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(17); exp_q.push_back(17); exp_q.push_back(16);
        end
        for (int i = 0; i < 6; i++) begin
            wait_toggle(n);
            check("f3_half_period", 32'(n));
        end

        // 4: clamp above and exactly at CLK_HZ, then silence
        frequency = 11'd60;
        for (int i = 0; i < 4; i++) exp_q.push_back(1);
        for (int i = 0; i < 4; i++) begin
            wait_toggle(n);
            check("f60_clamp_half_period", 32'(n));
        end
        frequency = 11'd50;
        for (int i = 0; i < 4; i++) exp_q.push_back(1);
        for (int i = 0; i < 4; i++) begin
            wait_toggle(n);
            check("f50_step_eq_clk_half_period", 32'(n));
        end
        frequency = 11'd0;
        @(posedge clk);
        #1;
        exp_q.push_back(0);
        check("f0_low_next_edge", 32'(clk_out));
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (clk_out !== 1'b0) hi++;
        end
        exp_q.push_back(0);
        check("f0_stays_low", 32'(hi));

        // 5: async reset mid-half-period at frequency=10
        frequency = 11'd10;
        exp_q.push_back(5);
        wait_toggle(n);
        check("f10_from_silence_first", 32'(n));
        @(posedge clk);
        @(posedge clk);
        #3;
        exp_q.push_back(1);
        check("high_before_reset", 32'(clk_out));
        rst_n = 1'b0;
        #1;
        exp_q.push_back(0);
        check("async_reset_low", 32'(clk_out));
        hi = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (clk_out !== 1'b0) hi++;
        end
        exp_q.push_back(0);
        check("reset_mid_hold_low", 32'(hi));
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(5);
        wait_toggle(n);
        check("f10_after_reset_first", 32'(n));

        // 6: switch 10 -> 1 with acc=40: phase continues, toggle when acc reaches 100
        @(posedge clk);
        @(posedge clk);
        #1;
        frequency = 11'd1;
        exp_q.push_back(30);
        exp_q.push_back(50);
        wait_toggle(n);
        check("switch_10_to_1_first", 32'(n));
        wait_toggle(n);
        check("switch_10_to_1_second", 32'(n));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
